// File: rtl/comms.sv
// ============================================================================
// comms - UART command/data bridge between a host serial link and a data BRAM
// Rev 1.0
// ============================================================================
`default_nettype none

module comms #(
  parameter int DATA_DEPTH      = 65536,
  parameter int DATA_BRAM_WIDTH = 64,
  parameter int DATA_PIECES     = 2,
  parameter int CLOCKS_PER_BAUD = 25,
  parameter int READ_LATENCY    = 2,
  localparam int AW             = $clog2(DATA_DEPTH)
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rx_in,
  input  logic [DATA_BRAM_WIDTH-1:0] data_register_in,
  output logic                       tx_out,
  output logic                       busy_out,
  output logic [AW-1:0]              data_addr_out,
  output logic [DATA_BRAM_WIDTH-1:0] data_register_out,
  output logic                       data_write_enable_out,
  output logic                       data_read_enable_out
);

  localparam int BYTES = DATA_BRAM_WIDTH / 8;
  localparam int BW    = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
  localparam int CW    = $clog2(BYTES + 3);
  localparam int PW    = $clog2(DATA_PIECES + 1);
  localparam int WW    = $clog2(READ_LATENCY + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLOCKS_PER_BAUD - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLOCKS_PER_BAUD / 2);

  // ---------------- UART receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t rx_state, rx_state_next;

  logic          rx_meta, rx_sync, rx_prev;
  logic [BW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_byte;
  logic          byte_valid;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) rx_state <= RX_IDLE;
    else        rx_state <= rx_state_next;
  end

  always_comb begin
    rx_state_next = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_state_next = RX_START;
      RX_START: if (rx_cnt == BAUD_HALF) rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_cnt == BAUD_LAST && rx_bit == 3'd7) rx_state_next = RX_STOP;
      RX_STOP:  if (rx_cnt == BAUD_LAST) rx_state_next = RX_IDLE;
      default:  rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
    end else begin
      rx_meta    <= rx_in;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      unique case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
        end
        RX_START: rx_cnt <= (rx_cnt == BAUD_HALF) ? '0 : rx_cnt + BW'(1);
        RX_DATA: begin
          if (rx_cnt == BAUD_LAST) begin
            rx_cnt  <= '0;
            rx_byte <= {rx_sync, rx_byte[7:1]};
            rx_bit  <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + BW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == BAUD_LAST) begin
            rx_cnt     <= '0;
            byte_valid <= rx_sync;  // stop bit low drops the byte
          end else begin
            rx_cnt <= rx_cnt + BW'(1);
          end
        end
        default: rx_cnt <= '0;
      endcase
    end
  end

  // ---------------- UART transmitter ----------------
  logic          tx_busy, tx_start, tx_last, tx_ready;
  logic [9:0]    tx_sh;
  logic [3:0]    tx_bit;
  logic [BW-1:0] tx_cnt;
  logic [7:0]    tx_byte;

  // A new byte may load on the final cycle of the previous stop bit.
  assign tx_last  = tx_busy && (tx_bit == 4'd9) && (tx_cnt == BAUD_LAST);
  assign tx_ready = !tx_busy || tx_last;
  assign tx_out   = tx_busy ? tx_sh[0] : 1'b1;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tx_busy <= 1'b0;
      tx_sh   <= '1;
      tx_bit  <= '0;
      tx_cnt  <= '0;
    end else if (tx_start && tx_ready) begin
      tx_busy <= 1'b1;
      tx_sh   <= {1'b1, tx_byte, 1'b0};
      tx_bit  <= '0;
      tx_cnt  <= '0;
    end else if (tx_busy) begin
      if (tx_cnt == BAUD_LAST) begin
        tx_cnt <= '0;
        tx_sh  <= {1'b1, tx_sh[9:1]};
        if (tx_bit == 4'd9) tx_busy <= 1'b0;
        else                tx_bit  <= tx_bit + 4'd1;
      end else begin
        tx_cnt <= tx_cnt + BW'(1);
      end
    end
  end

  // ---------------- Command FSM ----------------
  typedef enum logic [2:0] {IDLE, HDR, WR_DATA, WR_STROBE, RD_REQ, RD_WAIT, RD_SEND} state_t;
  state_t state, state_next;

  logic [CW-1:0]              cnt;
  logic [PW-1:0]              piece;
  logic [WW-1:0]              wait_cnt;
  logic                       op_read;
  logic [7:0]                 addr_lo;
  logic [AW-1:0]              addr;
  logic [DATA_BRAM_WIDTH-1:0] wdata, rdata;
  logic                       last_piece;

  assign last_piece            = (piece == PW'(DATA_PIECES - 1));
  assign tx_byte               = rdata[7:0];
  assign busy_out              = (state != IDLE);
  assign data_addr_out         = addr;
  assign data_register_out     = wdata;
  assign data_write_enable_out = (state == WR_STROBE);
  assign data_read_enable_out  = (state == RD_REQ);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx_start   = 1'b0;
    unique case (state)
      IDLE:      if (byte_valid) state_next = HDR;
      HDR:       if (byte_valid && cnt == CW'(2)) state_next = op_read ? RD_REQ : WR_DATA;
      WR_DATA:   if (byte_valid && cnt == CW'(BYTES - 1)) state_next = WR_STROBE;
      WR_STROBE: state_next = last_piece ? IDLE : WR_DATA;
      RD_REQ:    state_next = RD_WAIT;
      RD_WAIT:   if (wait_cnt == WW'(READ_LATENCY - 1)) state_next = RD_SEND;
      RD_SEND: begin
        if (cnt < CW'(BYTES)) tx_start = tx_ready;
        else if (tx_ready)    state_next = last_piece ? IDLE : RD_REQ;
      end
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt      <= '0;
      piece    <= '0;
      wait_cnt <= '0;
      op_read  <= 1'b0;
      addr_lo  <= '0;
      addr     <= '0;
      wdata    <= '0;
      rdata    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt   <= '0;
          piece <= '0;
          if (byte_valid) begin
            op_read <= rx_byte[2];
            cnt     <= CW'(1);
          end
        end
        HDR: begin
          if (byte_valid) begin
            if (cnt == CW'(1)) begin
              addr_lo <= rx_byte;
              cnt     <= CW'(2);
            end else begin
              addr <= AW'({rx_byte, addr_lo});
              cnt  <= '0;
            end
          end
        end
        WR_DATA: begin
          if (byte_valid) begin
            wdata <= {rx_byte, wdata[DATA_BRAM_WIDTH-1:8]};
            cnt   <= (cnt == CW'(BYTES - 1)) ? '0 : cnt + CW'(1);
          end
        end
        WR_STROBE: begin
          addr  <= addr + AW'(1);
          piece <= piece + PW'(1);
        end
        RD_REQ: wait_cnt <= '0;
        RD_WAIT: begin
          wait_cnt <= wait_cnt + WW'(1);
          if (wait_cnt == WW'(READ_LATENCY - 1)) rdata <= data_register_in;
        end
        RD_SEND: begin
          if (tx_start) begin
            rdata <= rdata >> 8;
            cnt   <= cnt + CW'(1);
          end else if (cnt == CW'(BYTES) && tx_ready) begin
            cnt   <= '0;
            addr  <= addr + AW'(1);
            piece <= piece + PW'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_comms.sv
// ============================================================================
// tb_comms - directed bench for the comms UART/BRAM bridge
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_comms;

  localparam int CPB = 25;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [63:0] bram_val = '0;
  logic [63:0] bram_p1, bram_p2;
  logic        tx_out, busy_out, we, re;
  logic [15:0] addr;
  logic [63:0] wdat;

  always #5 clk = ~clk;

  comms dut (
    .clk_in                (clk),
    .rst_in                (rst),
    .rx_in                 (rx),
    .data_register_in      (bram_p2),
    .tx_out                (tx_out),
    .busy_out              (busy_out),
    .data_addr_out         (addr),
    .data_register_out     (wdat),
    .data_write_enable_out (we),
    .data_read_enable_out  (re)
  );

  // Two-cycle BRAM read pipeline
  always @(posedge clk) begin
    bram_p1 <= bram_val;
    bram_p2 <= bram_p1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] wa_q[$];
  logic [63:0] wd_q[$];
  logic [15:0] ra_q[$];
  logic [7:0]  tx_q[$];
  int          tx_ferr = 0;

  always @(negedge clk) begin
    if (we) begin wa_q.push_back(addr); wd_q.push_back(wdat); end
    if (re) ra_q.push_back(addr);
  end

  // Serial decoder for tx_out
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx_out);
      repeat (CPB / 2) @(negedge clk);
      if (tx_out == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx_out;
        end
        repeat (CPB) @(negedge clk);
        if (tx_out === 1'b1) tx_q.push_back(b);
        else                 tx_ferr++;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (!stop) repeat (CPB) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [15:0] a);
    send_byte(op, 1'b1);
    send_byte(a[7:0], 1'b1);
    send_byte(a[15:8], 1'b1);
  endtask

  task automatic send_payload(input logic [127:0] pl);
    for (int k = 0; k < 16; k++) send_byte(pl[127 - 8*k -: 8], 1'b1);
  endtask

  task automatic wait_idle(input int lim, input string name);
    int n = 0;
    while (busy_out && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(name, {63'd0, busy_out}, 64'd0);
  endtask

  task automatic clear_q();
    wa_q.delete(); wd_q.delete(); ra_q.delete(); tx_q.delete();
    tx_ferr = 0;
  endtask

  typedef struct {
    logic [7:0]   op;
    logic [15:0]  a;
    logic [127:0] pl;
    logic [15:0]  ea0, ea1;
    logic [63:0]  ed0, ed1;
  } wr_vec_t;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] a;
    logic [63:0] word;
    logic [15:0] ea0, ea1;
    logic [63:0] eb;  // expected byte stream per word, first byte in [63:56]
  } rd_vec_t;

  wr_vec_t wv[3];
  rd_vec_t rv[2];

  initial begin
    wv[0] = '{8'h00, 16'h0000, 128'h3636363636363636_C9C9C9C9C9C9C9C9,
              16'h0000, 16'h0001, 64'h3636363636363636, 64'hC9C9C9C9C9C9C9C9};
    wv[1] = '{8'h01, 16'h1234, 128'h0102030405060708_1112131415161718,
              16'h1234, 16'h1235, 64'h0807060504030201, 64'h1817161514131211};
    wv[2] = '{8'h0B, 16'hFFFF, 128'hA5A5A5A5A5A5A5A5_5A5A5A5A5A5A5A5A,
              16'hFFFF, 16'h0000, 64'hA5A5A5A5A5A5A5A5, 64'h5A5A5A5A5A5A5A5A};
    rv[0] = '{8'h04, 16'h0000, 64'h6666666666666666, 16'h0000, 16'h0001, 64'h6666666666666666};
    rv[1] = '{8'h07, 16'hFFFF, 64'h0123456789ABCDEF, 16'hFFFF, 16'h0000, 64'hEFCDAB8967452301};

    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst tx_out", {63'd0, tx_out}, 64'd1);
    check("rst busy",   {63'd0, busy_out}, 64'd0);
    check("rst we",     {63'd0, we}, 64'd0);
    check("rst re",     {63'd0, re}, 64'd0);
    check("rst addr",   {48'd0, addr}, 64'd0);
    check("rst wdata",  wdat, 64'd0);
    repeat (5) @(negedge clk);

    // Write table
    for (int v = 0; v < 3; v++) begin
      clear_q();
      send_hdr(wv[v].op, wv[v].a);
      send_payload(wv[v].pl);
      wait_idle(200, $sformatf("wr%0d idle", v));
      repeat (5) @(negedge clk);
      check($sformatf("wr%0d count", v), 64'(wa_q.size()), 64'd2);
      if (wa_q.size() >= 2) begin
        check($sformatf("wr%0d addr0", v), {48'd0, wa_q[0]}, {48'd0, wv[v].ea0});
        check($sformatf("wr%0d data0", v), wd_q[0], wv[v].ed0);
        check($sformatf("wr%0d addr1", v), {48'd0, wa_q[1]}, {48'd0, wv[v].ea1});
        check($sformatf("wr%0d data1", v), wd_q[1], wv[v].ed1);
      end
    end

    // Same write message three times back-to-back
    clear_q();
    for (int m = 0; m < 3; m++) begin
      send_hdr(8'h00, 16'h0000);
      send_payload(128'h3636363636363636_C9C9C9C9C9C9C9C9);
      check($sformatf("b2b idle %0d", m), {63'd0, busy_out}, 64'd0);
    end
    repeat (5) @(negedge clk);
    check("b2b count", 64'(wa_q.size()), 64'd6);
    for (int i = 0; i < 6 && i < wa_q.size(); i++) begin
      check($sformatf("b2b addr%0d", i), {48'd0, wa_q[i]}, (i % 2 == 0) ? 64'd0 : 64'd1);
      check($sformatf("b2b data%0d", i), wd_q[i],
            (i % 2 == 0) ? 64'h3636363636363636 : 64'hC9C9C9C9C9C9C9C9);
    end

    // Read table
    for (int v = 0; v < 2; v++) begin
      clear_q();
      bram_val = rv[v].word;
      send_hdr(rv[v].op, rv[v].a);
      if (v == 1) begin
        // a byte arriving mid-transmission must not start anything
        repeat (600) @(negedge clk);
        send_byte(8'h00, 1'b1);
      end
      wait_idle(8000, $sformatf("rd%0d idle", v));
      repeat (CPB * 12) @(negedge clk);
      check($sformatf("rd%0d busy", v), {63'd0, busy_out}, 64'd0);
      check($sformatf("rd%0d tx idle", v), {63'd0, tx_out}, 64'd1);
      check($sformatf("rd%0d strobes", v), 64'(ra_q.size()), 64'd2);
      if (ra_q.size() >= 2) begin
        check($sformatf("rd%0d addr0", v), {48'd0, ra_q[0]}, {48'd0, rv[v].ea0});
        check($sformatf("rd%0d addr1", v), {48'd0, ra_q[1]}, {48'd0, rv[v].ea1});
      end
      check($sformatf("rd%0d nbytes", v), 64'(tx_q.size()), 64'd16);
      check($sformatf("rd%0d ferr", v), 64'(tx_ferr), 64'd0);
      check($sformatf("rd%0d no write", v), 64'(wa_q.size()), 64'd0);
      for (int i = 0; i < 16 && i < tx_q.size(); i++)
        check($sformatf("rd%0d byte%0d", v, i), {56'd0, tx_q[i]},
              {56'd0, rv[v].eb[63 - 8*(i % 8) -: 8]});
    end

    // Framing error inside a write payload
    clear_q();
    send_hdr(8'h00, 16'h0000);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'hEE, 1'b0);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    send_byte(8'h77, 1'b1);
    repeat (5) @(negedge clk);
    check("ferr early strobe", 64'(wa_q.size()), 64'd0);
    send_byte(8'h88, 1'b1);
    for (int k = 0; k < 8; k++) send_byte(8'h99, 1'b1);
    wait_idle(200, "ferr idle");
    repeat (5) @(negedge clk);
    check("ferr count", 64'(wa_q.size()), 64'd2);
    if (wa_q.size() >= 2) begin
      check("ferr data0", wd_q[0], 64'h8877665544332211);
      check("ferr data1", wd_q[1], 64'h9999999999999999);
    end

    // Reset mid-payload, then a normal command
    clear_q();
    send_hdr(8'h00, 16'h0040);
    for (int k = 0; k < 5; k++) send_byte(8'h77, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid-rst busy", {63'd0, busy_out}, 64'd0);
    check("mid-rst addr", {48'd0, addr}, 64'd0);
    send_hdr(wv[1].op, wv[1].a);
    send_payload(wv[1].pl);
    wait_idle(200, "post-rst idle");
    repeat (5) @(negedge clk);
    check("post-rst count", 64'(wa_q.size()), 64'd2);
    if (wa_q.size() >= 2) begin
      check("post-rst addr0", {48'd0, wa_q[0]}, 64'h1234);
      check("post-rst data1", wd_q[1], 64'h1817161514131211);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
